// File: rtl/wb_bus_wdt.sv
// Wishbone classic bus-cycle watchdog: pass-through with forced error ack on slave timeout.
// Optional `WB_WDT_IRQ_EN adds a registered wdt_irq output (set after a timeout, cleared by fault_clr).
module wb_bus_wdt #(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] DEADVAL = 32'hdeaddead
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        wb_m_cyc,
  input  logic        wb_m_stb,
  input  logic [31:0] wb_m_adr,
  output logic        wb_m_ack,
  output logic [31:0] wb_m_rdt,
  output logic        wb_s_cyc,
  output logic        wb_s_stb,
  output logic [31:0] wb_s_adr,
  input  logic        wb_s_ack,
  input  logic [31:0] wb_s_rdt,
  input  logic        fault_clr,
  output logic        fault_valid,
  output logic [31:0] fault_adr,
  output logic [7:0]  fault_cnt,
  output logic        fault_pulse
`ifdef WB_WDT_IRQ_EN
  ,
  output logic        wdt_irq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TOUT} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_fault_valid;
  logic [31:0] r_fault_adr;
  logic [7:0]  r_fault_cnt;
  logic        w_req, w_tout;

  assign w_req  = wb_m_cyc & wb_m_stb;
  assign w_tout = (r_state == S_TOUT);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cnt holds the index of the current strobed cycle while waiting
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req && !wb_s_ack) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_WAIT: begin
        if (wb_s_ack || !w_req) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = S_TOUT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The forced-ack cycle hides the transfer from the slave side and drops any late ack
  assign wb_s_cyc    = ~wb_rst & ~w_tout & wb_m_cyc;
  assign wb_s_stb    = ~wb_rst & ~w_tout & wb_m_stb;
  assign wb_s_adr    = wb_m_adr;
  assign wb_m_ack    = ~wb_rst & (w_tout | wb_s_ack);
  assign wb_m_rdt    = w_tout ? DEADVAL : wb_s_rdt;
  assign fault_pulse = w_tout;

  // A timeout coinciding with fault_clr restarts the status from this fault
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_fault_valid <= 1'b0;
      r_fault_adr   <= '0;
      r_fault_cnt   <= '0;
    end else if (w_tout) begin
      if (fault_clr)                 r_fault_cnt <= 8'd1;
      else if (r_fault_cnt != 8'hff) r_fault_cnt <= r_fault_cnt + 8'd1;
      if (!r_fault_valid || fault_clr) begin
        r_fault_valid <= 1'b1;
        r_fault_adr   <= wb_m_adr;
      end
    end else if (fault_clr) begin
      r_fault_valid <= 1'b0;
      r_fault_adr   <= '0;
      r_fault_cnt   <= '0;
    end
  end

  assign fault_valid = r_fault_valid;
  assign fault_adr   = r_fault_adr;
  assign fault_cnt   = r_fault_cnt;

`ifdef WB_WDT_IRQ_EN
  logic r_irq;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)         r_irq <= 1'b0;
    else if (w_tout)    r_irq <= 1'b1;
    else if (fault_clr) r_irq <= 1'b0;
  end

  assign wdt_irq = r_irq;
`endif

endmodule

// File: tb/tb_wb_bus_wdt.sv
// Directed bench for wb_bus_wdt (TIMEOUT=64): pass-through, forced ack, status, reset, saturation.
module tb_wb_bus_wdt;

  localparam int          TO   = 64;
  localparam logic [31:0] DEAD = 32'hdeaddead;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        wb_m_cyc, wb_m_stb;
  logic [31:0] wb_m_adr;
  logic        wb_m_ack;
  logic [31:0] wb_m_rdt;
  logic        wb_s_cyc, wb_s_stb;
  logic [31:0] wb_s_adr;
  logic        wb_s_ack;
  logic [31:0] wb_s_rdt;
  logic        fault_clr;
  logic        fault_valid;
  logic [31:0] fault_adr;
  logic [7:0]  fault_cnt;
  logic        fault_pulse;
`ifdef WB_WDT_IRQ_EN
  logic        wdt_irq;
`endif

  int n_cmp = 0;
  int n_err = 0;

  wb_bus_wdt #(.TIMEOUT(TO), .DEADVAL(DEAD)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wb_m_cyc(wb_m_cyc), .wb_m_stb(wb_m_stb), .wb_m_adr(wb_m_adr),
    .wb_m_ack(wb_m_ack), .wb_m_rdt(wb_m_rdt),
    .wb_s_cyc(wb_s_cyc), .wb_s_stb(wb_s_stb), .wb_s_adr(wb_s_adr),
    .wb_s_ack(wb_s_ack), .wb_s_rdt(wb_s_rdt),
    .fault_clr(fault_clr), .fault_valid(fault_valid), .fault_adr(fault_adr),
    .fault_cnt(fault_cnt), .fault_pulse(fault_pulse)
`ifdef WB_WDT_IRQ_EN
    , .wdt_irq(wdt_irq)
`endif
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_bus();
    wb_m_cyc = 1'b0; wb_m_stb = 1'b0; wb_s_ack = 1'b0; fault_clr = 1'b0;
  endtask

  // Transfer whose slave acks in cycle ack_at (counted from the first strobed cycle).
  task automatic xfer(input string tag, input logic [31:0] adr, input int ack_at,
                      input logic [31:0] data);
    int bad;
    bad = 0;
    wb_m_cyc = 1'b1; wb_m_stb = 1'b1; wb_m_adr = adr; wb_s_ack = 1'b0;
    #2;
    chk({tag, "_s_adr"}, wb_s_adr, adr);
    chk({tag, "_s_stb"}, 32'(wb_s_stb), 32'd1);
    for (int i = 0; i < ack_at; i++) begin
      if (i != 0) #2;
      if (wb_m_ack || fault_pulse) bad++;
      tick();
    end
    chk({tag, "_early_ack"}, 32'(bad), 32'd0);
    wb_s_ack = 1'b1; wb_s_rdt = data;
    #2;
    chk({tag, "_m_ack"}, 32'(wb_m_ack), 32'd1);
    chk({tag, "_m_rdt"}, wb_m_rdt, data);
    tick();
    idle_bus();
    #2;
    chk({tag, "_ack_drop"}, 32'(wb_m_ack), 32'd0);
  endtask

  // Hung transfer; slave tries a late ack in the forced-ack cycle; clr optionally in that cycle.
  task automatic run_tout(input string tag, input logic [31:0] adr, input bit do_chk,
                          input bit clr);
    int bad;
    bad = 0;
    wb_m_cyc = 1'b1; wb_m_stb = 1'b1; wb_m_adr = adr; wb_s_ack = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #2;
      if (wb_m_ack || fault_pulse || !wb_s_stb) bad++;
      tick();
    end
    wb_s_ack = 1'b1; wb_s_rdt = 32'h5a5a5a5a; fault_clr = clr;
    #2;
    if (do_chk) begin
      chk({tag, "_pre_bad"}, 32'(bad), 32'd0);
      chk({tag, "_f_ack"}, 32'(wb_m_ack), 32'd1);
      chk({tag, "_f_rdt"}, wb_m_rdt, DEAD);
      chk({tag, "_f_stb"}, 32'(wb_s_stb), 32'd0);
      chk({tag, "_f_cyc"}, 32'(wb_s_cyc), 32'd0);
      chk({tag, "_pulse"}, 32'(fault_pulse), 32'd1);
    end
    tick();
    idle_bus();
    #2;
    if (do_chk) begin
      chk({tag, "_pulse_end"}, 32'(fault_pulse), 32'd0);
      chk({tag, "_ack_end"}, 32'(wb_m_ack), 32'd0);
    end
  endtask

  initial begin
    wb_rst = 1'b1;
    wb_m_cyc = 1'b1; wb_m_stb = 1'b1; wb_m_adr = 32'h0; wb_s_ack = 1'b1;
    wb_s_rdt = 32'h0; fault_clr = 1'b0;
    #2;
    chk("rst_s_cyc", 32'(wb_s_cyc), 32'd0);
    chk("rst_s_stb", 32'(wb_s_stb), 32'd0);
    chk("rst_m_ack", 32'(wb_m_ack), 32'd0);
    chk("rst_fvalid", 32'(fault_valid), 32'd0);
    chk("rst_fadr", fault_adr, 32'd0);
    chk("rst_fcnt", 32'(fault_cnt), 32'd0);
    chk("rst_pulse", 32'(fault_pulse), 32'd0);
`ifdef WB_WDT_IRQ_EN
    chk("rst_irq", 32'(wdt_irq), 32'd0);
`endif
    idle_bus();
    tick(); tick();
    wb_rst = 1'b0;
    tick();

    // Normal read acked in cycle 1
    xfer("rd_ok", 32'h00000010, 1, 32'h12345678);
    chk("rd_ok_fvalid", 32'(fault_valid), 32'd0);

    // Unmapped read times out in cycle 64
    run_tout("t1", 32'h00C00000, 1'b1, 1'b0);
    chk("t1_fvalid", 32'(fault_valid), 32'd1);
    chk("t1_fadr", fault_adr, 32'h00C00000);
    chk("t1_fcnt", 32'(fault_cnt), 32'd1);
`ifdef WB_WDT_IRQ_EN
    chk("t1_irq", 32'(wdt_irq), 32'd1);
`endif
    tick();

    // Ack in cycle 63 wins over the timeout
    xfer("ack63", 32'h00000020, TO - 1, 32'hcafef00d);
    chk("ack63_pulse", 32'(fault_pulse), 32'd0);
    chk("ack63_fcnt", 32'(fault_cnt), 32'd1);
    tick();

    // Second timeout keeps the first address
    run_tout("t2", 32'h00D00000, 1'b1, 1'b0);
    chk("t2_fcnt", 32'(fault_cnt), 32'd2);
    chk("t2_fadr", fault_adr, 32'h00C00000);

    // Clear pulse
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    #2;
    chk("clr_fvalid", 32'(fault_valid), 32'd0);
    chk("clr_fadr", fault_adr, 32'd0);
    chk("clr_fcnt", 32'(fault_cnt), 32'd0);
`ifdef WB_WDT_IRQ_EN
    chk("clr_irq", 32'(wdt_irq), 32'd0);
`endif
    tick();

    // Timeout, then a clear coincident with the next timeout
    run_tout("t3", 32'h00E00000, 1'b0, 1'b0);
    chk("t3_fcnt", 32'(fault_cnt), 32'd1);
    tick();
    run_tout("t4", 32'h00F00000, 1'b1, 1'b1);
    chk("t4_fvalid", 32'(fault_valid), 32'd1);
    chk("t4_fadr", fault_adr, 32'h00F00000);
    chk("t4_fcnt", 32'(fault_cnt), 32'd1);
`ifdef WB_WDT_IRQ_EN
    chk("t4_irq", 32'(wdt_irq), 32'd1);
`endif
    tick();

    // Reset at cycle 30 of a hung transfer
    wb_m_cyc = 1'b1; wb_m_stb = 1'b1; wb_m_adr = 32'h000000F0; wb_s_ack = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    wb_rst = 1'b1;
    #2;
    chk("mid_rst_s_cyc", 32'(wb_s_cyc), 32'd0);
    chk("mid_rst_s_stb", 32'(wb_s_stb), 32'd0);
    chk("mid_rst_m_ack", 32'(wb_m_ack), 32'd0);
    tick();
    wb_rst = 1'b0;
    idle_bus();
    #2;
    chk("mid_rst_fcnt", 32'(fault_cnt), 32'd0);
    tick();
    // Ack in cycle 40 would collide with a stale count that was not cleared
    xfer("post_rst", 32'h00000030, 40, 32'h0badf00d);
    chk("post_rst_fcnt", 32'(fault_cnt), 32'd0);
    tick();

    // 300 consecutive timeouts saturate the counter
    for (int k = 0; k < 300; k++) run_tout("sat", 32'h00000100 + 32'(k), 1'b0, 1'b0);
    chk("sat_fcnt", 32'(fault_cnt), 32'd255);
    chk("sat_fadr", fault_adr, 32'h00000100);
    chk("sat_fvalid", 32'(fault_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
